// File: rtl/mem_types_pkg.sv
// Shared widths, burst FSM states and line helpers for the burst-memory path.
package mem_types_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(BEATS);

    localparam logic [31:0] LINE_ALIGN_MASK = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_CMD,
        RD_DATA,
        RESP
    } burst_state_t;

    // Beat k of a line lives in bits [64k+63:64k].
    typedef logic [BEATS-1:0][BEAT_W-1:0] line_beats_t;

    function automatic logic [BEAT_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx);
        line_beats_t beats;
        beats = line;
        return beats[idx];
    endfunction

endpackage

// File: rtl/line_burst_ctrl_if.sv
// Upstream line-request bus and bmem beat bus of the burst controller.
interface line_burst_ctrl_if;
    import mem_types_pkg::*;

    logic [ADDR_W-1:0] req_addr;
    logic              req_read;
    logic              req_write;
    logic [LINE_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_rdata;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  req_addr, req_read, req_write, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output req_addr, req_read, req_write, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/line_burst_ctrl_deser.sv
// Beat-indexed line buffer: writes one 64-bit slot per enabled cycle.
// Latency 1 cycle from we to line_out; no backpressure.
module line_deser
    import mem_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CNT_W-1:0]  idx,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line_out
);

    line_beats_t buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (we) begin
            buf_d[idx] = beat_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign line_out = buf_q;

endmodule

// File: rtl/line_burst_ctrl.sv
// Serializes one 256-bit line request into 4 bmem beats and reassembles read beats.
// Latency: write >= 4 WR cycles + 1 RESP; read = command wait + 4 matching beats + 1 RESP.
// Backpressure: bmem_ready stalls commands/beats with address/data held; req_ready only in IDLE.
module line_burst_ctrl
    import mem_types_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    line_burst_ctrl_if.slave         bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    burst_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic              is_wr_q, is_wr_d;

    logic              beat_we;
    logic [LINE_W-1:0] rd_line;

    line_deser u_deser (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (beat_we),
        .idx      (cnt_q),
        .beat_in  (bus.bmem_rdata),
        .line_out (rd_line)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wline_d         = wline_q;
        is_wr_d         = is_wr_q;
        beat_we         = 1'b0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.bmem_addr   = '0;
        bus.bmem_read   = 1'b0;
        bus.bmem_write  = 1'b0;
        bus.bmem_wdata  = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                cnt_d         = '0;
                // Write wins when both request lines are raised together.
                if (bus.req_write || bus.req_read) begin
                    addr_d  = bus.req_addr & ADDR_W'(LINE_ALIGN_MASK);
                    wline_d = bus.req_wdata;
                    is_wr_d = bus.req_write;
                    state_d = bus.req_write ? WR : RD_CMD;
                end
            end

            WR: begin
                bus.bmem_write = 1'b1;
                bus.bmem_addr  = addr_q;
                bus.bmem_wdata = get_beat(wline_q, cnt_q);
                if (bus.bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RD_CMD: begin
                bus.bmem_read = 1'b1;
                bus.bmem_addr = addr_q;
                if (bus.bmem_ready) begin
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                // Beats tagged for another line belong to someone else; drop them.
                if (bus.bmem_rvalid && (bus.bmem_raddr == addr_q)) begin
                    beat_we = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = is_wr_q ? '0 : rd_line;
                cnt_d          = '0;
                state_d        = IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            is_wr_q <= is_wr_d;
        end
    end

endmodule

// File: doc/line_burst_ctrl.md
Name: line_burst_ctrl

Overview:
- Sequences the shared burst-memory port on behalf of the cache arbiter.
- Accepts one 256-bit line transaction at a time (read or write-back) and serializes it into 4 beats of 64 bits toward bmem.
- For reads, it collects 4 returned beats into one line and hands the line back upstream.
- Sits between the cache arbiter's line-side outputs and the top-level bmem interface.

Parameters:
- BEATS, 4, beats per line burst.
- BEAT_W, 64, bmem data width in bits.
- LINE_W, 256, cache line width; must equal BEATS*BEAT_W.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_addr  in  ADDR_W  line address; bits [4:0] ignored, forced to 0 on the bmem side.
- req_read  in  1  line read request.
- req_write  in  1  line write request.
- req_wdata  in  LINE_W  write line; beat k = bits [64k+63:64k].
- req_ready  out  1  high only in IDLE; a request is accepted when (req_read|req_write) & req_ready.
- resp_valid  out  1  one-cycle pulse; transaction complete.
- resp_rdata  out  LINE_W  assembled read line; valid with resp_valid on reads, 0 on writes.
- bmem_addr  out  ADDR_W  aligned line address; 0 when idle.
- bmem_read  out  1  read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  current write beat.
- bmem_ready  in  1  bmem accepts command/beat this cycle.
- bmem_raddr  in  ADDR_W  address tag of the returning beat.
- bmem_rdata  in  BEAT_W  returning read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, beat counter=0, line buffer=0, every output 0 except req_ready=1.
- Reset mid-transaction aborts it: the partial line is discarded and no resp_valid is issued.
- Request capture (IDLE only):
  - Captures addr & ~32'h1F, the op, and req_wdata.
  - If req_read and req_write are both high, write wins.
  - req_ready drops the cycle after acceptance.
- States:
  - IDLE: on write go to WR, on read go to RD_CMD.
  - WR: bmem_write=1, bmem_addr=line addr, bmem_wdata=beat[cnt].
    - Beat advances (cnt++) only on cycles with bmem_ready.
    - After beat BEATS-1 is accepted, go to RESP.
    - Beats go out back-to-back when bmem_ready stays high, so minimum write latency is 4 cycles of WR plus 1 of RESP.
  - RD_CMD: bmem_read=1, bmem_addr=line addr, held until bmem_ready=1 (exactly one accepted command), then go to RD_DATA with cnt=0.
  - RD_DATA: a beat is taken when bmem_rvalid=1 and bmem_raddr equals the line addr.
    - The taken beat is stored to buffer slot cnt, then cnt++.
    - A beat with mismatched raddr is dropped and does not advance the count.
    - After beat BEATS-1 is stored, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_rdata=buffer (reads) or 0 (writes), then return to IDLE.
    - A new request can be accepted on the next cycle, not in RESP.
- Counter: $clog2(BEATS) bits, wraps to 0 on last beat, cleared on IDLE entry.
- Handshake holds: bmem_addr and bmem_wdata are stable while bmem_write or bmem_read is high and bmem_ready is low.
- bmem_rvalid outside RD_DATA is ignored (no state change).
- Upstream request inputs are ignored outside IDLE; requesters hold them until req_ready.
- The beat buffer is updated only in RD_DATA; resp_rdata is held 0 outside RESP.
- Only one transaction is outstanding at any time; no pipelining of line requests.

Decomposition:
- Shared package (mem_types_pkg): BEATS, BEAT_W, LINE_W, the enum burst_state_t {IDLE, WR, RD_CMD, RD_DATA, RESP}, and the LINE_ALIGN_MASK=32'hFFFF_FFE0 constant.
- One natural sub-module: line_deser, the beat-indexed 4x64 line buffer with write-enable and index; reused later for the write serializer mux.

Test Plan:
- Write line, bmem_ready=1 throughout: req_write, addr 0x1ECE_B014, wdata {64'hD,64'hC,64'hB,64'hA} -> bmem_addr=0x1ECE_B000; wdata beats A,B,C,D on 4 consecutive cycles; resp_valid 1 cycle later, resp_rdata=0.
- Write with backpressure: bmem_ready low on cycles 2–3 -> beat B held stable for those cycles; total 4 accepted beats; single resp_valid.
- Read: req_read, addr 0x0000_1040; beats 0x11,0x22,0x33,0x44 with raddr 0x1040 -> exactly one bmem_read accepted; resp_rdata={0x44,0x33,0x22,0x11} in 64-bit slots; resp_valid 1 cycle.
- Stray and mismatched beats: rvalid in IDLE, plus one beat with raddr 0x2000 mid-read -> beats ignored; assembled line is unchanged vs the clean read.
- Simultaneous req_read=req_write=1 -> write executed; no bmem_read issued.
- Async reset asserted after 2 read beats -> outputs 0 immediately; req_ready=1 after release; no resp_valid; next read completes correctly.
